// File: rtl/dma_pkg.sv
// Shared types and default widths for the single-word memory-to-memory DMA engine.
package dma_pkg;

  localparam int ADDR_W_DEFAULT = 4;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The embedded array is written only on the edge that leaves WRITE.
  function automatic logic is_write_phase(input state_t s);
    return (s == WRITE);
  endfunction

endpackage

// File: rtl/dma_if.sv
// Request and memory-port bundle between the DMA engine (master) and its environment (slave).
interface dma_if
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_we_n;
  logic              mem_ce_n;
  logic              done;

  modport master (
    input  start, src_addr, dst_addr, mem_data_out,
    output mem_addr, mem_data_in, mem_we_n, mem_ce_n, done
  );

  modport slave (
    output start, src_addr, dst_addr, mem_data_out,
    input  mem_addr, mem_data_in, mem_we_n, mem_ce_n, done
  );

endinterface

// File: rtl/dma_controller.sv
// Copies one word mem[src_addr] -> mem[dst_addr] per accepted start pulse, using an
// embedded register-file memory and a four-state Moore FSM with registered outputs.
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  dma_if.master  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Not reset: contents survive a reset so an aborted transfer leaves memory intact.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_n_q;
  logic              ce_n_q;
  logic              done_q;

  // Outputs are registered alongside the state so each one already holds the
  // value decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
      we_n_q <= 1'b1;
      ce_n_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            src_q  <= bus.src_addr;
            dst_q  <= bus.dst_addr;
            addr_q <= bus.src_addr;
            ce_n_q <= 1'b0;
            we_n_q <= 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          data_q <= bus.mem_data_out;
          addr_q <= dst_q;
          ce_n_q <= 1'b0;
          we_n_q <= 1'b0;
          state  <= WRITE;
        end
        WRITE: begin
          addr_q <= '0;
          ce_n_q <= 1'b1;
          we_n_q <= 1'b1;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          addr_q <= '0;
          ce_n_q <= 1'b1;
          we_n_q <= 1'b1;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // A reset during WRITE drops the state to IDLE before the edge, so no write occurs.
  always_ff @(posedge clk) begin
    if (is_write_phase(state)) begin
      mem[dst_q] <= data_q;
    end
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = data_q;
  assign bus.mem_we_n    = we_n_q;
  assign bus.mem_ce_n    = ce_n_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: directed cycle tables, reset-abort and
// back-to-back sequences, then random requests against a transfer-level reference model.
module tb_dma_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dma_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  dma_controller #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Environment memory port: read data for the presented address.
  assign bus.mem_data_out = dut.mem[bus.mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] addr, input logic ce_n,
                            input logic we_n, input logic done, input logic [7:0] din);
    check({tag, ".mem_addr"},    32'(bus.mem_addr),    32'(addr));
    check({tag, ".mem_ce_n"},    32'(bus.mem_ce_n),    32'(ce_n));
    check({tag, ".mem_we_n"},    32'(bus.mem_we_n),    32'(we_n));
    check({tag, ".done"},        32'(bus.done),        32'(done));
    check({tag, ".mem_data_in"}, 32'(bus.mem_data_in), 32'(din));
  endtask

  typedef struct {
    logic       st;
    logic [3:0] src;
    logic [3:0] dst;
    logic [3:0] addr;
    logic       ce_n;
    logic       we_n;
    logic       done;
    logic [7:0] din;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] ref_mem [16];
  int         done_cyc [$];

  initial begin
    int         e, free_at, acc, d;
    logic [3:0] a_src, a_dst, x_addr;
    logic [7:0] a_val, last_val;
    logic       x_ce_n, x_we_n, x_done;

    // Basic copy 5->A, start pulsed during WRITE (ignored), then src==dst on word 3.
    tbl[0]  = '{1'b1, 4'h5, 4'hA, 4'h5, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'h5, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0, 8'hAA};
    tbl[2]  = '{1'b0, 4'h5, 4'hA, 4'h0, 1'b1, 1'b1, 1'b1, 8'hAA};
    tbl[3]  = '{1'b0, 4'h5, 4'hA, 4'h0, 1'b1, 1'b1, 1'b0, 8'hAA};
    tbl[4]  = '{1'b1, 4'h5, 4'h6, 4'h5, 1'b0, 1'b1, 1'b0, 8'hAA};
    tbl[5]  = '{1'b0, 4'h5, 4'h6, 4'h6, 1'b0, 1'b0, 1'b0, 8'hAA};
    tbl[6]  = '{1'b1, 4'h1, 4'h2, 4'h0, 1'b1, 1'b1, 1'b1, 8'hAA};
    tbl[7]  = '{1'b0, 4'h1, 4'h2, 4'h0, 1'b1, 1'b1, 1'b0, 8'hAA};
    tbl[8]  = '{1'b0, 4'h1, 4'h2, 4'h0, 1'b1, 1'b1, 1'b0, 8'hAA};
    tbl[9]  = '{1'b1, 4'h3, 4'h3, 4'h3, 1'b0, 1'b1, 1'b0, 8'hAA};
    tbl[10] = '{1'b0, 4'h3, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 8'h5C};
    tbl[11] = '{1'b0, 4'h3, 4'h3, 4'h0, 1'b1, 1'b1, 1'b1, 8'h5C};
    tbl[12] = '{1'b0, 4'h3, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 8'h5C};

    bus.start    = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;

    // Asynchronous reset takes effect with no clock edge.
    #1 rst = 1'b1;
    #2;
    check_outs("reset", 4'h0, 1'b1, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #2 rst = 1'b0;

    dut.mem[5]  = 8'hAA;
    dut.mem[10] = 8'h00;
    dut.mem[6]  = 8'h00;
    dut.mem[1]  = 8'h77;
    dut.mem[2]  = 8'h33;
    dut.mem[3]  = 8'h5C;

    for (int i = 0; i < 13; i++) begin
      bus.start    = tbl[i].st;
      bus.src_addr = tbl[i].src;
      bus.dst_addr = tbl[i].dst;
      @(posedge clk);
      #1;
      check_outs($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].ce_n, tbl[i].we_n,
                 tbl[i].done, tbl[i].din);
    end
    check("copy.mem[A]",      32'(dut.mem[10]), 32'h00AA);
    check("copy.mem[5]",      32'(dut.mem[5]),  32'h00AA);
    check("busy.mem[6]",      32'(dut.mem[6]),  32'h00AA);
    check("busy.mem[2]",      32'(dut.mem[2]),  32'h0033);
    check("same.mem[3]",      32'(dut.mem[3]),  32'h005C);

    // Reset during READ: nothing written, no done pulse.
    dut.mem[7] = 8'h11;
    dut.mem[9] = 8'h00;
    bus.start = 1'b1; bus.src_addr = 4'h7; bus.dst_addr = 4'h9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rdabort.in_read_addr", 32'(bus.mem_addr), 32'h7);
    #3 rst = 1'b1;
    #1;
    check_outs("rdabort.async", 4'h0, 1'b1, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rdabort.no_done", 32'(bus.done), 32'h0);
    end
    check("rdabort.mem[9]", 32'(dut.mem[9]), 32'h00);

    // Reset during WRITE: destination keeps its old value.
    dut.mem[8] = 8'h42;
    dut.mem[4] = 8'h99;
    bus.start = 1'b1; bus.src_addr = 4'h8; bus.dst_addr = 4'h4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("wrabort.in_write_we_n", 32'(bus.mem_we_n), 32'h0);
    #3 rst = 1'b1;
    #1;
    check_outs("wrabort.async", 4'h0, 1'b1, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("wrabort.mem[4]", 32'(dut.mem[4]), 32'h99);

    // Back-to-back: start held high gives a transfer every four cycles.
    bus.start = 1'b1; bus.src_addr = 4'h1; bus.dst_addr = 4'hB;
    dut.mem[11] = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      if (i == 17) bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_cyc.push_back(i);
    end
    check("b2b.done_count", 32'(done_cyc.size()), 32'd4);
    if (done_cyc.size() > 0) check("b2b.first_done", 32'(done_cyc[0]), 32'd3);
    for (int i = 1; i < done_cyc.size(); i++)
      check("b2b.done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd4);
    check("b2b.mem[B]", 32'(dut.mem[11]), 32'h77);

    // Random requests against a transfer-level model.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom_range(0, 255));
      dut.mem[i] = ref_mem[i];
    end
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    last_val = 8'h00;
    e        = 0;
    free_at  = 0;
    acc      = -1000;
    a_src    = '0;
    a_dst    = '0;
    a_val    = '0;
    for (int k = 0; k < 400; k++) begin
      bus.start    = ($urandom_range(0, 2) != 0);
      bus.src_addr = 4'($urandom_range(0, 15));
      bus.dst_addr = 4'($urandom_range(0, 15));
      if (bus.start && e >= free_at) begin
        acc     = e;
        free_at = e + 4;
        a_src   = bus.src_addr;
        a_dst   = bus.dst_addr;
        a_val   = ref_mem[a_src];
      end
      @(posedge clk);
      #1;
      d      = e - acc;
      x_addr = 4'h0; x_ce_n = 1'b1; x_we_n = 1'b1; x_done = 1'b0;
      if (d == 0) begin
        x_addr = a_src; x_ce_n = 1'b0;
      end else if (d == 1) begin
        x_addr = a_dst; x_ce_n = 1'b0; x_we_n = 1'b0;
        last_val = a_val;
      end else if (d == 2) begin
        x_done = 1'b1;
        ref_mem[a_dst] = a_val;
      end
      check_outs($sformatf("rand[%0d]", k), x_addr, x_ce_n, x_we_n, x_done, last_val);
      e++;
    end
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++)
      check($sformatf("rand.mem[%0d]", i), 32'(dut.mem[i]), 32'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
